run_ctrl: RTL
=============

# run_ctrl

Run controller that sits directly upstream of the processor top level: it owns the processor's `reset` input and consumes its `done` output. On a start request it holds the core in reset for a fixed number of cycles, releases it, counts execution cycles until `done` is qualified or a timeout expires, then parks the core back in reset and reports status and cycle count. Bench and board wrappers drive `start` and read `busy`/`finished`/`timed_out`/`cycle_count` instead of sequencing the core reset by hand.

## Interface
Parameters:
- `CNT_W`, 16, width of the cycle counter.
- `RST_CYCLES`, 2, cycles `core_reset` is held high after a start (≥1).
- `MIN_RUN`, 2, run cycles before `core_done` is honoured (masks `done` glitches while the PC leaves its reset value).
- `TIMEOUT_CYC`, 1000, maximum run cycles (1 ≤ value ≤ 2^CNT_W − 1).

Ports:
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request a run; sampled as a level each cycle.
- `core_done` in 1: processor `done`.
- `core_reset` out 1: drives processor `reset`.
- `busy` out 1: high in HOLD and RUN.
- `finished` out 1: sticky; high in DONE.
- `done_pulse` out 1: one-cycle strobe on entry to DONE.
- `timed_out` out 1: sticky; high in TIMEOUT.
- `cycle_count` out CNT_W: number of cycles `core_reset` was low in the current/last run.

## Operation
- States: IDLE, HOLD, RUN, DONE, TIMEOUT. All outputs registered.
- Reset: state IDLE, `core_reset`=1, `busy`=0, `finished`=0, `done_pulse`=0, `timed_out`=0, `cycle_count`=0, hold counter 0.
- `core_reset`=0 only in RUN; 1 in every other state (core frozen; data memory contents stay readable).
- IDLE: `start`=1 → HOLD; clear `cycle_count` and hold counter.
- HOLD: hold counter increments each cycle; after exactly `RST_CYCLES` HOLD cycles → RUN. `start` ignored.
- RUN: `cycle_count` increments every RUN cycle, including the exiting one. Let q = `core_done` && (`cycle_count` ≥ `MIN_RUN`), evaluated on the pre-increment value.
  - q=1 → DONE; `done_pulse`=1 for the first DONE cycle.
  - else if `cycle_count` == `TIMEOUT_CYC` − 1 → TIMEOUT.
  - q and timeout in the same cycle: DONE wins.
  - `start` ignored.
- DONE / TIMEOUT: hold `cycle_count`; status sticky. `start`=1 → HOLD (new run; counters cleared, `finished`/`timed_out` cleared on entering HOLD).
- Counter never wraps: timeout fires before `cycle_count` can exceed `TIMEOUT_CYC`.
- `reset` during any state (including mid-RUN): next cycle IDLE with reset values; takes priority over `start`/`core_done`.

## Timing
- `start` sampled high at edge t → HOLD from t+1; `core_reset` high for cycles t+1 … t+RST_CYCLES; RUN (`core_reset`=0) from t+RST_CYCLES+1.
- `core_reset` continuously high from reset through HOLD (no low glitch between IDLE and HOLD).
- Qualified `core_done` in RUN cycle k (counter value k before increment) → DONE next cycle, `cycle_count` = k+1, `core_reset`=1 that same cycle.
- Timeout: `cycle_count` = `TIMEOUT_CYC` on entering TIMEOUT; `core_reset`=1 that cycle.
- `busy` falls the same cycle `finished` or `timed_out` rises.
- `start` held high continuously: one run per entry into DONE/TIMEOUT (restarts immediately; no extra cycles).

## Test plan
Parameters `RST_CYCLES`=2, `MIN_RUN`=2, `TIMEOUT_CYC`=20, `CNT_W`=16.
- Assert `reset` 3 cycles → `core_reset`=1, `busy`=0, `finished`=0, `timed_out`=0, `done_pulse`=0, `cycle_count`=0; stays IDLE with `start`=0.
- `start` pulse at cycle 0, `core_done`=0 → `core_reset`=1 at cycles 1–2, 0 from cycle 3; `core_done` raised when `cycle_count`=5 → next cycle `finished`=1, `done_pulse`=1 for one cycle, `cycle_count`=6, `core_reset`=1, `busy`=0.
- `core_done` tied high from start → ignored at counts 0 and 1; DONE with `cycle_count`=3.
- `core_done` never high → `timed_out`=1, `finished`=0, `cycle_count`=20, `core_reset`=1; values hold for 10 further cycles.
- `reset` asserted when `cycle_count`=7 in RUN → next cycle IDLE, `cycle_count`=0, `core_reset`=1, `busy`=0; a `start` pulse in the same cycle as `reset` is ignored.
- `start` pulsed during HOLD and RUN → no effect on count or state; `start` in DONE → HOLD next cycle with `finished`=0 and `cycle_count`=0; `core_done` and timeout coinciding at count 19 → DONE, `timed_out`=0.

Source files
------------

// File: rtl/run_ctrl.sv
// Run controller for the processor core: sequences core reset, counts run cycles
// until a qualified done or a timeout, then parks the core and reports status.
module run_ctrl #(
    parameter int CNT_W       = 16,
    parameter int RST_CYCLES  = 2,
    parameter int MIN_RUN     = 2,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             core_done,
    output logic             core_reset,
    output logic             busy,
    output logic             finished,
    output logic             done_pulse,
    output logic             timed_out,
    output logic [CNT_W-1:0] cycle_count
);

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        RUN,
        DONE,
        TIMEOUT
    } state_t;

    localparam int HOLD_W = $clog2(RST_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  MIN_RUN_C = CNT_W'(MIN_RUN);
    localparam logic [CNT_W-1:0]  RUN_LAST  = CNT_W'(TIMEOUT_CYC - 1);

    state_t              state_q, state_d;
    logic [HOLD_W-1:0]   holdCnt_q, holdCnt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                coreReset_q, coreReset_d;
    logic                busy_q, busy_d;
    logic                finished_q, finished_d;
    logic                donePulse_q, donePulse_d;
    logic                timedOut_q, timedOut_d;
    logic                qualDone;

    // Done is only trusted once the core has run long enough to leave its reset PC.
    assign qualDone = core_done && (cnt_q >= MIN_RUN_C);

    always_comb begin
        state_d   = state_q;
        holdCnt_d = holdCnt_q;
        cnt_d     = cnt_q;

        case (state_q)
            IDLE, DONE, TIMEOUT: begin
                if (start) begin
                    state_d   = HOLD;
                    holdCnt_d = '0;
                    cnt_d     = '0;
                end
            end
            HOLD: begin
                holdCnt_d = holdCnt_q + 1'b1;
                if (holdCnt_q == HOLD_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (qualDone) begin
                    state_d = DONE;
                end else if (cnt_q == RUN_LAST) begin
                    state_d = TIMEOUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they can be registered
        // without lagging the state by a cycle.
        coreReset_d = (state_d != RUN);
        busy_d      = (state_d == HOLD) || (state_d == RUN);
        finished_d  = (state_d == DONE);
        timedOut_d  = (state_d == TIMEOUT);
        donePulse_d = (state_d == DONE) && (state_q == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            holdCnt_q   <= '0;
            cnt_q       <= '0;
            coreReset_q <= 1'b1;
            busy_q      <= 1'b0;
            finished_q  <= 1'b0;
            donePulse_q <= 1'b0;
            timedOut_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            holdCnt_q   <= holdCnt_d;
            cnt_q       <= cnt_d;
            coreReset_q <= coreReset_d;
            busy_q      <= busy_d;
            finished_q  <= finished_d;
            donePulse_q <= donePulse_d;
            timedOut_q  <= timedOut_d;
        end
    end

    assign core_reset  = coreReset_q;
    assign busy        = busy_q;
    assign finished    = finished_q;
    assign done_pulse  = donePulse_q;
    assign timed_out   = timedOut_q;
    assign cycle_count = cnt_q;

endmodule
